// File: rtl/toggle_pkg.sv
// Shared types and default parameters for the toggle event counter.
package toggle_pkg;

  localparam int unsigned CNT_W_DEF       = 8;
  localparam int unsigned WINDOW_DEF      = 16;
  localparam int unsigned SYNC_STAGES_DEF = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/toggle_sync_edge.sv
// Synchronises an asynchronous toggle level and emits a one-cycle pulse per transition.
module toggle_sync_edge
  import toggle_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic q_in,
  output logic edge_pulse
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  // Chain resets to 0, so a high level at reset release reads as one transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync       <= '0;
      prev       <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      sync       <= {sync[SYNC_STAGES-2:0], q_in};
      prev       <= sync[SYNC_STAGES-1];
      edge_pulse <= sync[SYNC_STAGES-1] ^ prev;
    end
  end

endmodule

// File: rtl/toggle_event_counter.sv
// Counts toggle-level transitions per fixed window and offers each window total
// on a valid/ready port with sticky overflow and saturation flags.
module toggle_event_counter
  import toggle_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned WINDOW      = WINDOW_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             q_in,
  input  logic             clr,
  output logic             edge_pulse,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic             overflow,
  output logic             sat
);

  localparam int unsigned      WIN_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] ev_cnt;
  logic [CNT_W-1:0] snap;
  logic             win_end;
  logic             at_cap;
  logic             load;
  logic             drop;
  out_state_t       state;
  out_state_t       state_next;

  toggle_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk       (clk),
    .rst       (rst),
    .q_in      (q_in),
    .edge_pulse(edge_pulse)
  );

  assign win_end = (win_cnt == WIN_LAST);
  assign at_cap  = (ev_cnt == CNT_MAX);
  // The edge arriving in the closing cycle still belongs to the closing window.
  assign snap    = at_cap ? CNT_MAX : ev_cnt + CNT_W'(edge_pulse);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Output handshake: hold one total, drop later ones while unaccepted.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    drop       = 1'b0;
    case (state)
      EMPTY: begin
        if (win_end) begin
          load       = 1'b1;
          state_next = FULL;
        end
      end
      FULL: begin
        if (win_end) begin
          if (out_ready) begin
            load = 1'b1;
          end else begin
            drop = 1'b1;
          end
        end else if (out_ready) begin
          state_next = EMPTY;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt   <= '0;
      ev_cnt    <= '0;
      out_valid <= 1'b0;
      out_count <= '0;
      overflow  <= 1'b0;
      sat       <= 1'b0;
    end else if (clr) begin
      win_cnt   <= '0;
      ev_cnt    <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      sat       <= 1'b0;
    end else begin
      win_cnt <= win_end ? '0 : win_cnt + WIN_W'(1);
      if (win_end) begin
        ev_cnt <= '0;
      end else if (edge_pulse && !at_cap) begin
        ev_cnt <= ev_cnt + CNT_W'(1);
      end
      if (edge_pulse && at_cap) begin
        sat <= 1'b1;
      end
      if (load) begin
        out_count <= snap;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
      out_valid <= (state_next == FULL);
    end
  end

endmodule

// File: tb/tb_toggle_event_counter.sv
// Directed bench for toggle_event_counter with a window-level reference model.
module tb_toggle_event_counter;

  logic       clk;
  logic       rst;
  logic       m_q, m_clr, m_ready;
  logic       m_edge, m_valid, m_ovf, m_sat;
  logic [7:0] m_count;
  logic       s_q, s_clr, s_ready;
  logic       s_edge, s_valid, s_ovf, s_sat;
  logic [2:0] s_count;

  int total = 0;
  int bad   = 0;
  bit started = 1'b0;
  bit m_tog = 1'b0;
  bit m_level = 1'b0;
  bit tog_ph = 1'b0;

  // Reference state: sample history, window position, running edge total, port state.
  typedef struct packed {
    bit [3:0] h;
    bit       e;
    int       cyc;
    int       sum;
    bit       valid;
    int       cnt;
    bit       ovf;
    bit       sat;
  } model_t;

  model_t mm, ms;

  toggle_event_counter #(.CNT_W(8), .WINDOW(16), .SYNC_STAGES(2)) u_main (
    .clk(clk), .rst(rst), .q_in(m_q), .clr(m_clr), .edge_pulse(m_edge),
    .out_valid(m_valid), .out_ready(m_ready), .out_count(m_count),
    .overflow(m_ovf), .sat(m_sat)
  );

  toggle_event_counter #(.CNT_W(3), .WINDOW(16), .SYNC_STAGES(2)) u_small (
    .clk(clk), .rst(rst), .q_in(s_q), .clr(s_clr), .edge_pulse(s_edge),
    .out_valid(s_valid), .out_ready(s_ready), .out_count(s_count),
    .overflow(s_ovf), .sat(s_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of the reference: pulse = level sampled 2 clocks ago vs 3 clocks ago.
  function automatic model_t step(model_t m, bit r, bit q, bit c, bit rdy, int maxv, int win);
    model_t n;
    int tot;
    n = m;
    if (r) begin
      n = '0;
      return n;
    end
    n.h = {m.h[2:0], q};
    n.e = n.h[2] ^ n.h[3];
    if (c) begin
      n.cyc = 0; n.sum = 0; n.valid = 1'b0; n.ovf = 1'b0; n.sat = 1'b0;
      return n;
    end
    if (m.cyc == win - 1) begin
      tot = m.sum + int'(m.e);
      if (tot > maxv) begin
        n.sat = 1'b1;
        tot = maxv;
      end
      n.sum = 0;
      if (!m.valid) begin
        n.valid = 1'b1;
        n.cnt = tot;
      end else if (rdy) begin
        n.cnt = tot;
      end else begin
        n.ovf = 1'b1;
      end
    end else begin
      n.sum = m.sum + int'(m.e);
      if (n.sum > maxv) n.sat = 1'b1;
      if (m.valid && rdy) n.valid = 1'b0;
    end
    n.cyc = (m.cyc + 1) % win;
    return n;
  endfunction

  always @(posedge clk) begin
    mm <= step(mm, rst, m_q, m_clr, m_ready, 255, 16);
    ms <= step(ms, rst, s_q, s_clr, s_ready, 7, 16);
    if (rst) started <= 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the reference for both instances.
  always @(negedge clk) begin
    if (started) begin
      check("m_edge",  32'(m_edge),  32'(mm.e));
      check("m_valid", 32'(m_valid), 32'(mm.valid));
      check("m_count", 32'(m_count), 32'(mm.cnt));
      check("m_ovf",   32'(m_ovf),   32'(mm.ovf));
      check("m_sat",   32'(m_sat),   32'(mm.sat));
      check("s_edge",  32'(s_edge),  32'(ms.e));
      check("s_valid", 32'(s_valid), 32'(ms.valid));
      check("s_count", 32'(s_count), 32'(ms.cnt));
      check("s_ovf",   32'(s_ovf),   32'(ms.ovf));
      check("s_sat",   32'(s_sat),   32'(ms.sat));
    end
  end

  // Main-instance level source: toggles every 2 clocks when enabled.
  always @(negedge clk) begin
    if (m_tog) begin
      if (tog_ph) m_q = ~m_q;
      tog_ph = ~tog_ph;
    end else begin
      m_q = m_level;
    end
  end

  task automatic wait_phase(input int ph, input bit need_valid, input string name);
    for (int i = 0; i < 200; i++) begin
      if (mm.cyc == ph && (!need_valid || m_valid === 1'b1)) return;
      @(negedge clk);
    end
    total++;
    bad++;
    $display("FAIL %s: timeout waiting for phase %0d valid %0d", name, ph, need_valid);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    rst = 1'b1; m_q = 1'b0; m_clr = 1'b0; m_ready = 1'b0;
    s_q = 1'b0; s_clr = 1'b0; s_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_edge",  32'(m_edge),  32'd0);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_count", 32'(m_count), 32'd0);
    check("rst_ovf",   32'(m_ovf),   32'd0);
    check("rst_sat",   32'(m_sat),   32'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("idle_edge", 32'(m_edge), 32'd0);
    end

    // Steady toggling: one edge every 2 clocks gives 8 per 16-clock window.
    m_ready = 1'b1;
    m_tog = 1'b1;
    repeat (64) @(negedge clk);
    check("steady_cnt", 32'(m_count), 32'd8);

    // Stall the consumer across three window ends.
    wait_phase(2, 1'b0, "stall_start");
    m_ready = 1'b0;
    repeat (48) @(negedge clk);
    check("stall_valid", 32'(m_valid), 32'd1);
    check("stall_cnt",   32'(m_count), 32'd8);
    check("stall_ovf",   32'(m_ovf),   32'd1);
    wait_phase(5, 1'b0, "accept_phase");
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    check("accept_valid", 32'(m_valid), 32'd0);
    check("accept_ovf",   32'(m_ovf),   32'd1);
    repeat (20) @(negedge clk);
    check("ovf_sticky", 32'(m_ovf), 32'd1);
    m_clr = 1'b1;
    @(negedge clk);
    m_clr = 1'b0;
    check("clr_ovf",   32'(m_ovf),   32'd0);
    check("clr_valid", 32'(m_valid), 32'd0);

    // Accept exactly in the window-end clock while holding a total.
    wait_phase(15, 1'b1, "we_accept");
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    check("we_valid", 32'(m_valid), 32'd1);
    check("we_ovf",   32'(m_ovf),   32'd0);
    check("we_cnt",   32'(m_count), 32'd8);

    // Clear mid-window with a stable high level.
    m_tog = 1'b0;
    m_level = 1'b1;
    m_ready = 1'b1;
    repeat (8) @(negedge clk);
    wait_phase(7, 1'b0, "clr_mid");
    m_clr = 1'b1;
    @(negedge clk);
    m_clr = 1'b0;
    check("clrmid_valid", 32'(m_valid), 32'd0);
    check("clrmid_edge",  32'(m_edge),  32'd0);
    repeat (15) @(negedge clk);
    check("clrmid_pre_end", 32'(m_valid), 32'd0);
    @(negedge clk);
    check("clrmid_end_valid", 32'(m_valid), 32'd1);
    check("clrmid_end_cnt",   32'(m_count), 32'd0);

    // Narrow counter: 10 edges in one window saturate at 7.
    s_clr = 1'b1;
    @(negedge clk);
    s_clr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      s_q = ~s_q;
      @(negedge clk);
    end
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (s_valid === 1'b1) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL sat_wait: timeout waiting for narrow total");
    end
    check("sat_cnt",  32'(s_count), 32'd7);
    check("sat_flag", 32'(s_sat),   32'd1);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
